// File: rtl/inverter_test_seq_pkg.sv
// rtl/inverter_test_seq_pkg.sv - shared types, LFSR constants and stimulus helpers for the inverter tester
package inv_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_ALT  = 2'd0,
        MODE_ZERO = 2'd1,
        MODE_ONE  = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    // Taps for x^8+x^6+x^5+x^4+1 on a right-shifting register: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {^(cur & LFSR_TAPS), cur[7:1]};
    endfunction

    function automatic logic stim_bit(input mode_e m, input logic [7:0] idx, input logic [7:0] lfsr);
        logic b;
        case (m)
            MODE_ALT:  b = idx[0];
            MODE_ZERO: b = 1'b0;
            MODE_ONE:  b = 1'b1;
            default:   b = lfsr[0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/inverter_test_seq_if.sv
// rtl/inverter_test_seq_if.sv - run-control and status bundle of the inverter tester
interface inverter_test_seq_if;
    logic       start;
    logic [1:0] mode;
    logic [7:0] num_vec;
    logic       busy;
    logic       done;
    logic [7:0] err_cnt;
    logic [7:0] vec_idx;

    modport master (
        output start, mode, num_vec,
        input  busy, done, err_cnt, vec_idx
    );

    modport slave (
        input  start, mode, num_vec,
        output busy, done, err_cnt, vec_idx
    );
endinterface

// File: rtl/inverter_test_seq_sync2.sv
// rtl/inverter_test_seq_sync2.sv - two-flop synchronizer for the asynchronous inverter response
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/inverter_test_seq.sv
// rtl/inverter_test_seq.sv - drives stimulus vectors into an inverter and counts response mismatches
module inverter_test_seq
    import inv_test_pkg::*;
#(
    parameter int         SETTLE_CYC = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    inverter_test_seq_if.slave   ctl,
    input  logic                 resp_in,
    output logic                 stim_out
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_e     state;
    mode_e      mode_q;
    logic [7:0] num_q;
    logic [3:0] cnt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic       resp_sync;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (resp_in),
        .q   (resp_sync)
    );

    assign lfsr_nxt = lfsr_step(lfsr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_ALT;
            num_q       <= 8'd0;
            cnt         <= 4'd0;
            lfsr        <= LFSR_SEED;
            stim_out    <= 1'b0;
            ctl.busy    <= 1'b0;
            ctl.done    <= 1'b0;
            ctl.err_cnt <= 8'd0;
            ctl.vec_idx <= 8'd0;
        end else begin
            ctl.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        mode_q      <= mode_e'(ctl.mode);
                        num_q       <= ctl.num_vec;
                        ctl.err_cnt <= 8'd0;
                        ctl.vec_idx <= 8'd0;
                        lfsr        <= LFSR_SEED;
                        ctl.busy    <= 1'b1;
                        if (ctl.num_vec == 8'd0) begin
                            state    <= ST_DONE;
                            ctl.done <= 1'b1;
                        end else begin
                            // Vector 0 uses the seed directly since lfsr is reloaded on this same edge
                            stim_out <= stim_bit(mode_e'(ctl.mode), 8'd0, LFSR_SEED);
                            cnt      <= CNT_LOAD;
                            state    <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if ((resp_sync != ~stim_out) && (ctl.err_cnt != 8'hFF)) begin
                        ctl.err_cnt <= ctl.err_cnt + 8'd1;
                    end
                    lfsr <= lfsr_nxt;
                    if (ctl.vec_idx == num_q - 8'd1) begin
                        state    <= ST_DONE;
                        ctl.done <= 1'b1;
                    end else begin
                        ctl.vec_idx <= ctl.vec_idx + 8'd1;
                        stim_out    <= stim_bit(mode_q, ctl.vec_idx + 8'd1, lfsr_nxt);
                        cnt         <= CNT_LOAD;
                        state       <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    ctl.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/inverter_test_seq.md
INVERTER_TEST_SEQ -- requirements
Module: inverter_test_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 4, SHALL set the cycles between stimulus update and response sample; legal range 2..15.
REQ-002 Parameter LFSR_SEED, default 8'hA5, SHALL set the nonzero LFSR seed reloaded on every accepted start.
REQ-003 clk  in  1  single clock; the block SHALL use one clock and reset only.
REQ-004 rst  in  1  reset; it SHALL be synchronous and active-high.
REQ-005 start  in  1  run request, sampled only in IDLE.
REQ-006 mode  in  2  pattern select: 0 alternating, 1 all-zero, 2 all-one, 3 LFSR.
REQ-007 num_vec  in  8  vectors per run; 0 is legal.
REQ-008 resp_in  in  1  digitized inverter output, asynchronous to clk.
REQ-009 stim_out  out  1  drive to the inverter input.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  single-cycle completion pulse.
REQ-012 err_cnt  out  8  mismatch count of the current or last run, saturating.
REQ-013 vec_idx  out  8  index of the vector under test.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 In IDLE with start=1, the block SHALL latch mode and num_vec, clear err_cnt and vec_idx, and reload the LFSR with LFSR_SEED.
REQ-016 On that start edge with num_vec=0, the next state SHALL be DONE; err_cnt stays 0 and stim_out is unchanged.
REQ-017 On that start edge with num_vec>0, the next state SHALL be SETTLE; stim_out takes vector 0 and the settle counter loads SETTLE_CYC-1.
REQ-018 The stimulus bit for vector i SHALL be: mode 0, i[0]; mode 1, 0; mode 2, 1; mode 3, lfsr[0].
REQ-019 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, and SHALL advance once per vector in SAMPLE.
REQ-020 SETTLE SHALL decrement the counter each cycle and move to SAMPLE on the cycle the counter equals 0; each vector therefore takes SETTLE_CYC+1 cycles.
REQ-021 resp_in SHALL pass through a 2-flop synchronizer; SAMPLE compares the synchronized value against ~stim_out.
REQ-022 On a SAMPLE mismatch, err_cnt SHALL increment by 1 and hold at 255 once it reaches 255.
REQ-023 After SAMPLE, when vec_idx = num_vec-1 the next state SHALL be DONE.
REQ-024 Otherwise, after SAMPLE the block SHALL increment vec_idx, drive the next vector on stim_out, reload the counter and return to SETTLE.
REQ-025 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-026 For a start sampled at edge k, done SHALL be high in cycle k+1+num_vec*(SETTLE_CYC+1).
REQ-027 start outside IDLE SHALL be ignored; mode and num_vec changes during a run SHALL have no effect.
REQ-028 After a run, err_cnt, vec_idx and stim_out SHALL hold their values until the next accepted start or reset.

Reset
REQ-029 While rst=1 at a clk edge, the state SHALL become IDLE.
REQ-030 The same reset edge SHALL clear stim_out, busy, done, err_cnt, vec_idx, the counter and both synchronizer flops, and load the LFSR with LFSR_SEED.
REQ-031 A reset during a run SHALL abort it with no done pulse.

Structure
REQ-032 Package inv_test_pkg SHALL hold the state enum, the mode enum and the LFSR tap-mask constant.
REQ-033 The synchronizer SHALL be a separate sub-module, sync2.

Verification
REQ-034 SETTLE_CYC=4, mode 0, num_vec=4, resp_in=~stim_out delayed 1 cycle, start at edge k -> stim_out sequence 0,1,0,1; done at k+21; err_cnt=0.
REQ-035 mode 2, num_vec=3, resp_in tied 1 -> err_cnt=3 and stim_out=1 at done.
REQ-036 mode 1, num_vec=255, resp_in tied 0 -> err_cnt saturates at 255; next start clears it to 0.
REQ-037 num_vec=0 with start -> done high in the next cycle; busy high for that 1 cycle only; err_cnt=0.
REQ-038 mode 3 with a correct inverter model -> stim_out matches the reference LFSR from seed 8'hA5; err_cnt=0.
REQ-039 start re-asserted mid-run, then rst asserted mid-run -> repeated start ignored; after the reset edge all outputs are 0 and no done pulse occurs.
